// File: rtl/reg_bank_pkg.sv
// Shared CPU register-file constants and flat-bus slicing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_bank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 32;

    // Architectural zero register; never stored, never counted.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of one register slice on the flat o_regs bus; the ID-stage mux
    // wiring uses the same stride so both sides agree on slice k placement.
    localparam int SLICE_STRIDE = DATA_W_DEF;

    // Low bit of register k on the flat bus.
    function automatic int slice_lo(input int k);
        return k * SLICE_STRIDE;
    endfunction

endpackage

// File: rtl/reg_cell.sv
// One architectural register: DATA_W flops with load enable.
// Latency: 1 cycle from i_en/i_d to o_q.
// Backpressure: none; a load is always accepted.
module reg_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    // Hold state unless loaded; async clear wins over everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// 32x32 register bank: one WB write/cycle, all entries driven flat to ID muxes.
// Latency: write visible next cycle; same cycle on the write-through path.
// Backpressure: none; every enabled write to a nonzero register commits.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int WRITE_THROUGH = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_we,
    input  logic [ADDR_W-1:0]            i_wr_addr,
    input  logic [DATA_W-1:0]            i_wr_data,
    output logic [DATA_W*(2**ADDR_W)-1:0] o_regs,
    output logic [15:0]                  o_wr_count,
    output logic                         o_wr_ovf
);

    localparam int NUM_ENT = 2 ** ADDR_W;

    logic                                wr_commit;
    logic [NUM_ENT-1:1]                  cell_en;
    logic [NUM_ENT-1:1][DATA_W-1:0]      stored;

    // Writes to the zero register are dropped here, so neither storage nor
    // counter nor forwarding ever sees them. Holding reset also blocks the
    // forward path so the outputs read zero while reset is low.
    assign wr_commit = reset_n && i_we && (i_wr_addr != ADDR_W'(REG_ZERO));

    // One-hot write decode over entries 1..NUM_ENT-1.
    always_comb begin
        cell_en = '0;
        for (int k = 1; k < NUM_ENT; k++) begin
            cell_en[k] = wr_commit && (i_wr_addr == ADDR_W'(k));
        end
    end

    // Entry 0 is a constant and has no storage.
    for (genvar k = 1; k < NUM_ENT; k++) begin : g_cell
        reg_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .i_en    (cell_en[k]),
            .i_d     (i_wr_data),
            .o_q     (stored[k])
        );
    end

    // Flat output bus; the entry being written shows the incoming data when
    // forwarding is enabled, which matches the value stored after the edge.
    always_comb begin
        o_regs = '0;
        for (int k = 1; k < NUM_ENT; k++) begin
            if ((WRITE_THROUGH != 0) && cell_en[k]) begin
                o_regs[k*DATA_W +: DATA_W] = i_wr_data;
            end else begin
                o_regs[k*DATA_W +: DATA_W] = stored[k];
            end
        end
    end

    // Committed-write counter with sticky wrap flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_wr_count <= '0;
            o_wr_ovf   <= 1'b0;
        end else if (wr_commit) begin
            o_wr_count <= o_wr_count + 16'd1;
            if (o_wr_count == 16'hFFFF) begin
                o_wr_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench: write-through and stored-only banks against an array model.
// Latency: model commits on each rising edge, forwarding checked before it.
// Backpressure: n/a.
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_we;
    logic [4:0]    i_wr_addr;
    logic [31:0]   i_wr_data;
    logic [1023:0] regs_wt, regs_nwt;
    logic [15:0]   cnt_wt, cnt_nwt;
    logic          ovf_wt, ovf_nwt;

    always #5 clk = ~clk;

    reg_bank #(.DATA_W(32), .ADDR_W(5), .WRITE_THROUGH(1)) u_dut_wt (
        .clk(clk), .reset_n(reset_n), .i_we(i_we), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .o_regs(regs_wt), .o_wr_count(cnt_wt), .o_wr_ovf(ovf_wt)
    );

    reg_bank #(.DATA_W(32), .ADDR_W(5), .WRITE_THROUGH(0)) u_dut_nwt (
        .clk(clk), .reset_n(reset_n), .i_we(i_we), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .o_regs(regs_nwt), .o_wr_count(cnt_nwt), .o_wr_ovf(ovf_nwt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural model: plain array of register values plus write tally.
    logic [31:0] model [32];
    int          model_cnt;
    bit          model_ovf;

    function automatic void model_reset();
        for (int k = 0; k < 32; k++) model[k] = '0;
        model_cnt = 0;
        model_ovf = 1'b0;
    endfunction

    // Applied at a rising edge with the inputs as they stood at that edge.
    function automatic void model_commit();
        if (reset_n === 1'b1 && i_we === 1'b1 && i_wr_addr != 5'd0) begin
            model[i_wr_addr] = i_wr_data;
            model_cnt = (model_cnt + 1) % 65536;
            if (model_cnt == 0) model_ovf = 1'b1;
        end
    endfunction

    // What the bus should show right now; wt selects the forwarding view.
    function automatic logic [1023:0] exp_bus(input bit wt);
        logic [1023:0] b;
        b = '0;
        for (int k = 1; k < 32; k++) begin
            if (wt && i_we === 1'b1 && i_wr_addr == k)
                b[slice_lo(k) +: 32] = i_wr_data;
            else
                b[slice_lo(k) +: 32] = model[k];
        end
        return b;
    endfunction

    function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
        for (int k = 0; k < 32; k++)
            if (a[k*32 +: 32] !== b[k*32 +: 32]) return k;
        return 0;
    endfunction

    function automatic logic [31:0] slice_of(input logic [1023:0] a, input int k);
        return a[k*32 +: 32];
    endfunction

    // Stimulus helpers: drive just after the falling edge, commit at the rising edge.
    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        i_we = we; i_wr_addr = a; i_wr_data = d;
        #1;
    endtask

    task automatic edge_commit();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_we = 1'b0; reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [1023:0] e;
        int k;
        reset_n = 1'b0; i_we = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        model_reset();
        #1;
        n_cmp++;
        if (regs_wt !== '0 || cnt_wt !== 16'd0 || ovf_wt !== 1'b0) begin
            n_bad++; $display("FAIL reset_initial: cnt %h ovf %b slice %0d = %h, want all 0", cnt_wt, ovf_wt, first_diff(regs_wt, '0), slice_of(regs_wt, first_diff(regs_wt, '0)));
        end
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom);
            edge_commit();
        end
        drive(1'b0, 5'd0, 32'd0);
        e = exp_bus(1'b0);
        n_cmp++;
        if (regs_wt !== e || cnt_wt !== 16'(model_cnt)) begin
            k = first_diff(regs_wt, e);
            n_bad++; $display("FAIL prewrite: slice %0d got %h want %h, cnt %h want %h", k, slice_of(regs_wt, k), slice_of(e, k), cnt_wt, 16'(model_cnt));
        end
        // Reset between edges must clear without any clock.
        #2; reset_n = 1'b0; model_reset();
        #1;
        n_cmp++;
        if (regs_wt !== '0 || regs_nwt !== '0 || cnt_wt !== 16'd0 || cnt_nwt !== 16'd0 || ovf_wt !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_edge: wt slice %0d = %h, nwt slice %0d = %h, cnt %h/%h, want all 0", first_diff(regs_wt, '0), slice_of(regs_wt, first_diff(regs_wt, '0)), first_diff(regs_nwt, '0), slice_of(regs_nwt, first_diff(regs_nwt, '0)), cnt_wt, cnt_nwt);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (regs_wt !== '0 || regs_nwt !== '0 || cnt_wt !== 16'd0 || ovf_wt !== 1'b0 || ovf_nwt !== 1'b0) begin
            n_bad++; $display("FAIL reset_held: cnt %h ovf %b/%b, want 0", cnt_wt, ovf_wt, ovf_nwt);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_basic_write();
        logic [1023:0] e;
        int k;
        apply_reset();
        drive(1'b1, 5'd5, 32'hDEADBEEF);  edge_commit();
        drive(1'b1, 5'd31, 32'h12345678); edge_commit();
        drive(1'b0, 5'd0, 32'd0);
        e = '0;
        e[5*32 +: 32]  = 32'hDEADBEEF;
        e[31*32 +: 32] = 32'h12345678;
        n_cmp++;
        if (regs_wt !== e || regs_nwt !== e) begin
            k = first_diff(regs_wt, e);
            n_bad++; $display("FAIL basic_bus: slice %0d got %h/%h want %h", k, slice_of(regs_wt, k), slice_of(regs_nwt, k), slice_of(e, k));
        end
        n_cmp++;
        if (cnt_wt !== 16'd2 || cnt_nwt !== 16'd2) begin
            n_bad++; $display("FAIL basic_count: got %0d/%0d want 2", cnt_wt, cnt_nwt);
        end
    endtask

    task automatic test_zero_reg();
        logic [15:0] cnt_before;
        logic [1023:0] e;
        int k;
        cnt_before = 16'(model_cnt);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 32'hFFFFFFFF);
            n_cmp++;
            if (slice_of(regs_wt, 0) !== 32'd0 || slice_of(regs_nwt, 0) !== 32'd0) begin
                n_bad++; $display("FAIL zero_fwd: cycle %0d slice0 %h/%h want 0", i, slice_of(regs_wt, 0), slice_of(regs_nwt, 0));
            end
            edge_commit();
            n_cmp++;
            if (slice_of(regs_wt, 0) !== 32'd0 || cnt_wt !== cnt_before || cnt_nwt !== cnt_before) begin
                n_bad++; $display("FAIL zero_store: cycle %0d slice0 %h cnt %h/%h want 0 and %h", i, slice_of(regs_wt, 0), cnt_wt, cnt_nwt, cnt_before);
            end
        end
        // Undriven write data with the enable low must leave state alone.
        drive(1'b0, 5'($urandom_range(1, 31)), 32'bx);
        edge_commit();
        e = exp_bus(1'b0);
        n_cmp++;
        if (regs_wt !== e || regs_nwt !== e || cnt_wt !== cnt_before) begin
            k = first_diff(regs_wt, e);
            n_bad++; $display("FAIL idle_x_data: slice %0d got %h want %h cnt %h", k, slice_of(regs_wt, k), slice_of(e, k), cnt_wt);
        end
    endtask

    task automatic test_write_through();
        drive(1'b1, 5'd7, 32'h1111); edge_commit();
        drive(1'b1, 5'd7, 32'h2222);
        n_cmp++;
        if (slice_of(regs_wt, 7) !== 32'h2222) begin
            n_bad++; $display("FAIL wt_same_cycle: r7 got %h want 00002222", slice_of(regs_wt, 7));
        end
        n_cmp++;
        if (slice_of(regs_nwt, 7) !== 32'h1111) begin
            n_bad++; $display("FAIL nwt_same_cycle: r7 got %h want 00001111", slice_of(regs_nwt, 7));
        end
        edge_commit();
        n_cmp++;
        if (slice_of(regs_wt, 7) !== 32'h2222 || slice_of(regs_nwt, 7) !== 32'h2222) begin
            n_bad++; $display("FAIL wt_after_edge: r7 got %h/%h want 00002222", slice_of(regs_wt, 7), slice_of(regs_nwt, 7));
        end
        drive(1'b0, 5'd7, 32'h0);
        n_cmp++;
        if (slice_of(regs_wt, 7) !== 32'h2222 || slice_of(regs_nwt, 7) !== 32'h2222) begin
            n_bad++; $display("FAIL wt_idle: r7 got %h/%h want 00002222", slice_of(regs_wt, 7), slice_of(regs_nwt, 7));
        end
    endtask

    task automatic test_reset_mid_write();
        drive(1'b1, 5'd3, 32'hAAAA);
        #3; reset_n = 1'b0; model_reset();
        edge_commit();
        i_we = 1'b0;
        #1;
        n_cmp++;
        if (slice_of(regs_wt, 3) !== 32'd0 || slice_of(regs_nwt, 3) !== 32'd0 || cnt_wt !== 16'd0) begin
            n_bad++; $display("FAIL mid_write_reset: r3 %h/%h cnt %h want 0", slice_of(regs_wt, 3), slice_of(regs_nwt, 3), cnt_wt);
        end
        @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        #1;
        n_cmp++;
        if (regs_wt !== '0 || cnt_wt !== 16'd0 || cnt_nwt !== 16'd0) begin
            n_bad++; $display("FAIL mid_write_release: r3 %h cnt %h want 0", slice_of(regs_wt, 3), cnt_wt);
        end
    endtask

    task automatic test_random();
        logic [1023:0] ew, en;
        int k;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
            ew = exp_bus(1'b1);
            en = exp_bus(1'b0);
            n_cmp++;
            if (regs_wt !== ew) begin
                k = first_diff(regs_wt, ew);
                n_bad++; $display("FAIL rand_wt: iter %0d slice %0d got %h want %h", i, k, slice_of(regs_wt, k), slice_of(ew, k));
            end
            n_cmp++;
            if (regs_nwt !== en) begin
                k = first_diff(regs_nwt, en);
                n_bad++; $display("FAIL rand_nwt: iter %0d slice %0d got %h want %h", i, k, slice_of(regs_nwt, k), slice_of(en, k));
            end
            edge_commit();
            n_cmp++;
            if (cnt_wt !== 16'(model_cnt) || cnt_nwt !== 16'(model_cnt)) begin
                n_bad++; $display("FAIL rand_count: iter %0d got %h/%h want %h", i, cnt_wt, cnt_nwt, 16'(model_cnt));
            end
        end
    endtask

    task automatic test_counter_wrap();
        logic [1023:0] e;
        int k;
        apply_reset();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 5'((i % 31) + 1), 32'(i * 7));
            edge_commit();
        end
        n_cmp++;
        if (cnt_wt !== 16'hFFFF || ovf_wt !== 1'b0 || ovf_nwt !== 1'b0) begin
            n_bad++; $display("FAIL wrap_pre: cnt %h ovf %b/%b want ffff 0", cnt_wt, ovf_wt, ovf_nwt);
        end
        drive(1'b1, 5'd9, 32'hCAFE0001); edge_commit();
        n_cmp++;
        if (cnt_wt !== 16'h0000 || cnt_nwt !== 16'h0000 || ovf_wt !== 1'b1 || ovf_nwt !== 1'b1 || model_ovf != 1'b1) begin
            n_bad++; $display("FAIL wrap: cnt %h/%h ovf %b/%b want 0000 1", cnt_wt, cnt_nwt, ovf_wt, ovf_nwt);
        end
        drive(1'b1, 5'd10, 32'hCAFE0002); edge_commit();
        n_cmp++;
        if (cnt_wt !== 16'd1 || ovf_wt !== 1'b1 || ovf_nwt !== 1'b1) begin
            n_bad++; $display("FAIL wrap_sticky: cnt %h ovf %b/%b want 0001 1", cnt_wt, ovf_wt, ovf_nwt);
        end
        drive(1'b0, 5'd0, 32'd0);
        e = exp_bus(1'b0);
        n_cmp++;
        if (regs_wt !== e || regs_nwt !== e) begin
            k = first_diff(regs_wt, e);
            n_bad++; $display("FAIL wrap_contents: slice %0d got %h want %h", k, slice_of(regs_wt, k), slice_of(e, k));
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_write_through();
        test_reset_mid_write();
        test_random();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 32-entry x 32-bit general-purpose register bank for the pipelined CPU.
- Holds architectural register state and drives all 32 register values in parallel to the ID-stage 32-to-1 read multiplexers, one instance per read port.
- Accepts one write per cycle from the WB stage.
- Provides write-through so an ID-stage read of the register being written in the same cycle returns the new value, which removes the WB to ID hazard.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; entry count is 2**ADDR_W.
- WRITE_THROUGH, 1, 1 means o_regs shows i_wr_data combinationally for the entry being written this cycle; 0 means o_regs shows stored state only.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_we  input  1  write enable from WB stage.
- i_wr_addr  input  ADDR_W  destination register number.
- i_wr_data  input  DATA_W  write-back data.
- o_regs  output  DATA_W*32  flat bus; bits [DATA_W*k+DATA_W-1 : DATA_W*k] are register k. Slice k feeds mux input i_data<k>.
- o_wr_count  output  16  count of committed writes since reset; used for debug and verification.
- o_wr_ovf  output  1  sticky flag set when o_wr_count wraps.

Behaviour:
- Reset:
  - Asserting reset_n low clears all 32 entries, o_wr_count and o_wr_ovf to 0 immediately, with no clock edge needed.
  - Deassertion is synchronised externally; the block needs no extra logic for it.
  - Reset asserted during a write cycle: the write is lost and the entry reads 0.
- Register 0:
  - Hardwired to zero.
  - A write to address 0 is discarded and o_regs slice 0 is always 0, including the write-through path.
  - It does not increment o_wr_count.
- Committed write:
  - Occurs on a rising edge with reset_n=1, i_we=1 and i_wr_addr!=0.
  - Entry[i_wr_addr] <= i_wr_data; write latency is 1 cycle.
  - Every other entry holds its value.
  - o_wr_count increments by 1.
- Write-through (WRITE_THROUGH=1):
  - While i_we=1 and i_wr_addr=k (k!=0), slice k of o_regs equals i_wr_data combinationally in the same cycle.
  - All other slices show stored values.
  - After the edge, the stored value equals the forwarded value, so the output does not glitch across the edge.
- WRITE_THROUGH=0: o_regs shows stored values only; a new value is visible the cycle after the write.
- Counter:
  - 16-bit wrap-around counter: 0xFFFF plus one committed write gives 0x0000.
  - On that wrap, o_wr_ovf is set to 1 and stays set until reset.
- No read-side state: reads are purely the external mux selection over o_regs; the block has no read ports.
- i_wr_data X/Z with i_we=0 must not corrupt state.
- Combinational path from i_we/i_wr_addr/i_wr_data to o_regs exists only when WRITE_THROUGH=1.

Decomposition:
- Shared CPU package holds:
  - REG_ZERO = 5'd0
  - NUM_REGS = 32
  - DATA_W/ADDR_W defaults
  - a localparam for the flat-bus slice offset, used by both this block and the ID-stage mux wiring.
- One natural sub-module: reg_cell.
  - Single DATA_W register with async active-low clear and write enable.
  - Instantiated 31 times by generate for entries 1..31; entry 0 is a constant.
- The write decoder, write-through select and counter stay in reg_bank.

Test Plan:
- Reset check: hold reset_n=0 for 2 cycles after random pre-writes -> every o_regs slice is 0x00000000, o_wr_count=0, o_wr_ovf=0; assert reset_n=0 between clock edges -> outputs clear without an edge.
- Basic write: write 0xDEADBEEF to r5, then 0x12345678 to r31 -> slice 5 = 0xDEADBEEF, slice 31 = 0x12345678, all other slices 0, o_wr_count=2.
- Zero register: i_we=1, i_wr_addr=0, i_wr_data=0xFFFFFFFF for 3 cycles -> slice 0 stays 0 on both the write-through and stored paths, o_wr_count unchanged.
- Write-through: r7 holds 0x1111; in the same cycle, drive i_we=1, i_wr_addr=7, i_wr_data=0x2222 -> slice 7 reads 0x2222 before the edge with WRITE_THROUGH=1 and 0x1111 with WRITE_THROUGH=0; after the edge, both configurations read 0x2222.
- Reset mid-write: drive a write of 0xAAAA to r3, pull reset_n low 1 ns before the edge, release after 2 cycles -> r3=0, o_wr_count=0.
- Counter wrap: issue 65536 committed writes to r1..r31 round-robin -> o_wr_count=0x0000 and o_wr_ovf=1; one more write -> o_wr_count=1 and o_wr_ovf stays 1.
